rol_seq: RTL and testbench



---
 rtl/rol_seq.sv | 80 ++++++++
 tb/tb_rol_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rol_seq.sv
// Multi-cycle rotate-left unit: rotates Rb left by Rc[4:0] one bit per clock,
// with a start/busy/done handshake and a registered result on Ra.
module rol_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] Rb,
  input  logic [4:0]       Rc,
  output logic [WIDTH-1:0] Ra,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] ra_nxt;

  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      Ra    <= '0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      cnt   <= cnt_nxt;
      Ra    <= ra_nxt;
    end
  end

  // A zero count bypasses ROTATE so the identity result still takes one cycle.
  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    cnt_nxt   = cnt;
    ra_nxt    = Ra;
    case (state)
      IDLE: begin
        if (start) begin
          data_nxt = Rb;
          cnt_nxt  = Rc;
          if (Rc == 5'd0) begin
            ra_nxt    = Rb;
            state_nxt = DONE;
          end else begin
            state_nxt = ROTATE;
          end
        end
      end
      ROTATE: begin
        data_nxt = rol1(data);
        cnt_nxt  = cnt - 5'd1;
        if (cnt == 5'd1) begin
          ra_nxt    = rol1(data);
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rol_seq.sv
// Self-checking bench for rol_seq: directed boundary cases plus randomized
// operations compared every cycle against a timing/result model.
module tb_rol_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] Rb = '0;
  logic [4:0]  Rc = '0;
  logic [31:0] Ra;
  logic        busy, done;

  rol_seq #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .Rb(Rb), .Rc(Rc),
    .Ra(Ra), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_rol(input logic [31:0] v, input int n);
    int k;
    k = n % 32;
    if (k == 0) return v;
    return (v << k) | (v >> (32 - k));
  endfunction

  // Model: cycle index j is the period following edge j. An op accepted at
  // edge t0 with count n is busy in cycles t0..t0+n, done in cycle t0+n,
  // and Ra shows its result from cycle t0+n on.
  int          edge_cnt = 0;
  bit          m_active = 0;
  int          m_t0 = 0;
  int          m_end = 0;
  logic [31:0] m_rot = '0;
  logic [31:0] m_last = '0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_active <= 0;
      m_last   <= '0;
      chk_en   <= 1;
    end else if ((!m_active || edge_cnt > m_end) && start) begin
      m_t0     <= edge_cnt + 1;
      m_end    <= edge_cnt + 1 + int'(Rc);
      m_rot    <= ref_rol(Rb, int'(Rc));
      m_active <= 1;
      if (m_active) m_last <= m_rot;
    end
    edge_cnt <= edge_cnt + 1;
  end

  int exp_done_cnt = 0;
  int dut_done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_busy, e_done;
      logic [31:0] e_ra;
      e_busy = m_active && edge_cnt >= m_t0 && edge_cnt <= m_end;
      e_done = m_active && edge_cnt == m_end;
      e_ra   = (m_active && edge_cnt >= m_end) ? m_rot : m_last;
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("Ra", Ra, e_ra);
      if (e_done) exp_done_cnt++;
      if (done)   dut_done_cnt++;
    end
  end

  // Drive start at a negedge; return busy-cycle count; leave at an IDLE-cycle negedge.
  task automatic run_op(input logic [31:0] rb, input logic [4:0] rc, output int busy_cycles);
    bit seen;
    Rb = rb; Rc = rc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Rb = $urandom; Rc = 5'($urandom);
    busy_cycles = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int bc;
    int d0;
    bit seen;

    check("model_rol_4",  ref_rol(32'h12345678, 4),  32'h23456781);
    check("model_rol_31", ref_rol(32'h00000001, 31), 32'h80000000);
    check("model_rol_0",  ref_rol(32'hDEADBEEF, 0),  32'hDEADBEEF);

    clr = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_Ra", Ra, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    run_op(32'h12345678, 5'd4, bc);
    check("basic_Ra", Ra, 32'h23456781);
    check("basic_busy_cycles", bc, 32'd5);
    repeat (3) @(negedge clk);
    check("basic_Ra_hold", Ra, 32'h23456781);

    run_op(32'hDEADBEEF, 5'd0, bc);
    check("rc0_Ra", Ra, 32'hDEADBEEF);
    check("rc0_busy_cycles", bc, 32'd1);

    run_op(32'h00000001, 5'd31, bc);
    check("rc31_Ra", Ra, 32'h80000000);
    check("rc31_busy_cycles", bc, 32'd32);

    run_op(32'h80000001, 5'd1, bc);
    check("rc1_Ra", Ra, 32'h00000003);

    // Start during rotation must be dropped.
    d0 = dut_done_cnt;
    Rb = 32'h0000000F; Rc = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    Rb = 32'hFFFFFFFF; Rc = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_Ra", Ra, 32'h00000F00);
    check("ignored_done_cnt", dut_done_cnt - d0, 32'd1);

    // Reset in the middle of a long rotation.
    d0 = dut_done_cnt;
    Rb = 32'h13579BDF; Rc = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_Ra", Ra, 32'h0);
    repeat (25) @(negedge clk);
    check("midrst_no_done", dut_done_cnt - d0, 32'd0);
    run_op(32'hA5A5A5A5, 5'd1, bc);
    check("after_rst_Ra", Ra, 32'h4B4B4B4B);

    // Randomized back-to-back operations with a single IDLE gap.
    d0 = dut_done_cnt;
    for (int i = 0; i < 500; i++) begin
      logic [31:0] rb;
      logic [4:0]  rc;
      rb = $urandom;
      rc = 5'($urandom_range(0, 31));
      run_op(rb, rc, bc);
      check("rand_Ra", Ra, ref_rol(rb, int'(rc)));
      check("rand_busy_cycles", bc, 32'(int'(rc) + 1));
    end
    check("rand_done_cnt", dut_done_cnt - d0, 32'd500);

    repeat (2) @(negedge clk);
    check("total_done_cnt", dut_done_cnt, exp_done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
